// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter.
// The divider register is copied into a per-frame divider at each grant.
module uart_tx_arbiter #(
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_we,
  input  logic [31:0] div_wdata,
  output logic [31:0] div_rdata,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        ser_tx,
  output logic        busy,
  output logic        last_grant
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] div_reg;
  logic [31:0] frame_div;
  logic [31:0] period;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_n;
  logic [2:0]  bit_nx;
  logic [7:0]  shreg;
  logic        tx;
  logic        tx_n;
  logic        last_q;
  logic        grant0;
  logic        grant1;
  logic        bit_end;

  // Divider values below 2 are clamped so every bit has a defined middle.
  assign period  = (frame_div < 32'd2) ? 32'd2 : frame_div;
  assign bit_end = (cnt == period - 32'd1);
  assign bit_nx  = bit_cnt + 3'd1;

  assign div_rdata  = div_reg;
  assign ser_tx     = tx;
  assign busy       = (state != IDLE);
  assign last_grant = last_q;
  assign req0_ready = grant0 & ~reset;
  assign req1_ready = grant1 & ~reset;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_q))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  // tx_n is the line level for the next cycle, so ser_tx stays registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          state_n = START;
          cnt_n   = 32'd0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n  = 1'b0;
        cnt_n = cnt + 32'd1;
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = 32'd0;
          bit_n   = 3'd0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        tx_n  = shreg[bit_cnt];
        cnt_n = cnt + 32'd1;
        if (bit_end) begin
          cnt_n = 32'd0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_nx;
            tx_n  = shreg[bit_nx];
          end
        end
      end
      STOP: begin
        tx_n  = 1'b1;
        cnt_n = cnt + 32'd1;
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = 32'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      last_q    <= 1'b1;
      div_reg   <= 32'(DEFAULT_DIV);
      frame_div <= 32'(DEFAULT_DIV);
      cnt       <= 32'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      if (div_we)
        div_reg <= div_wdata;
      if (grant0 || grant1) begin
        shreg     <= grant0 ? req0_data : req1_data;
        frame_div <= div_reg;
        last_q    <= grant1;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DEFAULT_DIV, default 6, which is the reset value of the bit-period divider in clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port div_we, input, 1 bit: write strobe for the divider register.
REQ-005 The block SHALL have port div_wdata, input, 32 bits: new divider value.
REQ-006 The block SHALL have port div_rdata, output, 32 bits: current divider register value.
REQ-007 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: the requester has a byte to send.
REQ-008 The block SHALL have ports req0_data and req1_data, input, 8 bits each: the byte offered by each requester.
REQ-009 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the byte is accepted this cycle.
REQ-010 The block SHALL have port ser_tx, output, 1 bit: serial line, 8N1 format, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port last_grant, output, 1 bit: index of the most recently granted requester.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 A handshake SHALL occur when reqN_valid and reqN_ready are both high in the same cycle.
REQ-015 reqN_ready SHALL be combinational and asserted only in IDLE, for at most one requester per cycle.
REQ-016 Arbitration in IDLE: if exactly one reqN_valid is high, that requester SHALL be granted.
REQ-017 Arbitration in IDLE: if both reqN_valid are high, the requester with index != last_grant SHALL be granted (round-robin).
REQ-018 On a handshake, the block SHALL capture reqN_data, latch the divider into a frame divider, set last_grant=N and enter START on the next cycle.
REQ-019 The effective bit period SHALL be max(frame divider, 2) cycles; divider values 0 and 1 behave as 2.
REQ-020 ser_tx SHALL be 0 during START, carry data bits LSB first in DATA (bit counter 0..7), and be 1 during STOP, each bit lasting exactly one bit period.
REQ-021 After STOP the FSM SHALL return to IDLE; frame-to-frame period is 10*period+1 cycles (one IDLE cycle with ser_tx=1).
REQ-022 ser_tx SHALL fall exactly 1 cycle after the handshake cycle.
REQ-023 A div_we write SHALL update div_rdata on the next cycle and affect only frames handshaken afterwards; the in-flight frame keeps its frame divider.
REQ-024 reqN_valid deasserting without a handshake SHALL be legal and SHALL have no effect; reqN_data is sampled only in the handshake cycle.
REQ-025 No requester SHALL be granted outside IDLE, even if valid is held through the entire frame.
REQ-026 ser_tx SHALL be registered (glitch-free output).

Reset
REQ-027 On reset: state=IDLE, ser_tx=1, busy=0, last_grant=1 (req0 wins the first tie), divider=DEFAULT_DIV, and bit counter and cycle counter = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame: ser_tx=1 from the next cycle, the byte is dropped, and no ready is asserted during reset.
REQ-029 reqN_ready SHALL be 0 in any cycle where reset is high.

Verification
REQ-030 Scenario: reset, req0_valid=1, data 0x55, req1 idle -> req0_ready pulses 1 cycle; ser_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 6 cycles; busy for 60 cycles.
REQ-031 Scenario: both valid from reset, req0=0x41, req1=0x42, held -> frames go out in the order 0x41, 0x42, 0x41, 0x42; each frame starts 61 cycles after the previous one.
REQ-032 Scenario: div_we with value 10 written mid-frame of 0x00 -> the current frame keeps 6-cycle bits; the next frame uses 10-cycle bits; div_rdata=10 one cycle after the write.
REQ-033 Scenario: divider written to 0, send 0xFF -> bit period 2 cycles; start bit low for 2 cycles, then 18 cycles high.
REQ-034 Scenario: reset asserted 20 cycles into a frame, with req1 valid -> ser_tx=1 next cycle; after reset deasserts, req1 is granted and a full fresh frame is sent.
REQ-035 A UART monitor sampling at mid-bit SHALL decode every byte transmitted across all scenarios exactly.
